uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 111 +++++++++++
 tb/tb_uart_rx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver for 7/8 data bits with optional odd/even parity.
// Define UART_RX_MAJORITY_EN to vote each bit 2-of-3 around the nominal sample point.
module uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        clr,
  input  logic [18:0] k,
  input  logic        eight,
  input  logic        parity_en,
  input  logic        ohel,
  output logic [7:0]  data,
  output logic        RXRDY,
  output logic        PERR,
  output logic        FERR,
  output logic        OVF
);
  typedef enum logic [1:0] {IDLE, START, DATA, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic [18:0] cnt_q, cnt_d, start_c;
  logic [3:0]  idx_q, idx_d, last_idx;
  logic [9:0]  sh_q, sh_d;
  logic [7:0]  data_q, data_d, dat;
  logic        rdy_q, rdy_d, perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic        rx_s, bit_v, par;
  assign rx_s = sync_q[1];
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rx_s};
  // Votes over counts c-1, c, c+1; decision lands one cycle after the nominal point.
  assign bit_v   = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign start_c = {1'b0, k[18:1]} + 19'd1;
`else
  assign bit_v   = rx_s;
  assign start_c = {1'b0, k[18:1]};
`endif
  assign last_idx = 4'd7 + {3'b000, eight} + {3'b000, parity_en};
  // Shift register fills from the MSB, so the stop bit always ends up in bit 9.
  assign dat = eight ? (parity_en ? sh_q[7:0] : sh_q[8:1])
                     : {1'b0, parity_en ? sh_q[7:1] : sh_q[8:2]};
  assign par = sh_q[8];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 19'd1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    rdy_d   = rdy_q & ~clr;
    ovf_d   = ovf_q & ~clr;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (cnt_q >= start_c) begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = bit_v ? IDLE : DATA;
      end
      DATA: if (cnt_q >= k) begin
        cnt_d = '0;
        sh_d  = {bit_v, sh_q[9:1]};
        idx_d = idx_q + 4'd1;
        if (idx_q >= last_idx) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        data_d  = dat;
        perr_d  = parity_en & (^dat ^ par ^ ohel);
        ferr_d  = ~sh_q[9];
        ovf_d   = rdy_q & ~clr;
        rdy_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  assign data  = data_q;
  assign RXRDY = rdy_q;
  assign PERR  = perr_q;
  assign FERR  = ferr_q;
  assign OVF   = ovf_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a frame-level model of uart_rx.
`timescale 1ns/1ps
module tb_uart_rx;
  logic        clk = 1'b0, rst = 1'b1, rx = 1'b1, clr = 1'b0;
  logic [18:0] k = 19'd15;
  logic        eight = 1'b1, parity_en = 1'b1, ohel = 1'b0;
  logic [7:0]  data;
  logic        RXRDY, PERR, FERR, OVF;
  int          n_checks = 0, n_fails = 0;
  logic [7:0]  m_data = 8'h00;
  logic        m_rdy = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  uart_rx dut (.clk(clk), .rst(rst), .rx(rx), .clr(clr), .k(k), .eight(eight),
               .parity_en(parity_en), .ohel(ohel), .data(data), .RXRDY(RXRDY),
               .PERR(PERR), .FERR(FERR), .OVF(OVF));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"}, data, m_data);
    chk({tag, ".rxrdy"}, {7'b0, RXRDY}, {7'b0, m_rdy});
    chk({tag, ".perr"}, {7'b0, PERR}, {7'b0, m_perr});
    chk({tag, ".ferr"}, {7'b0, FERR}, {7'b0, m_ferr});
    chk({tag, ".ovf"}, {7'b0, OVF}, {7'b0, m_ovf});
  endtask

  // Line image of one frame for the current format; returns the bit count.
  task automatic build(input logic [7:0] d, input logic pbit, input logic stop,
                       output logic [11:0] f, output int nb);
    f = '1;
    f[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < 7 + int'(eight); i++) begin f[nb] = d[i]; nb++; end
    if (parity_en) begin f[nb] = pbit; nb++; end
    f[nb] = stop;
    nb++;
  endtask

  // Expected register contents after a completed frame carrying data d as sampled.
  task automatic model_frame(input logic [7:0] d, input logic pbit, input logic stop,
                             input logic clr_done);
    m_data = eight ? d : {1'b0, d[6:0]};
    m_perr = parity_en && ((($countones(m_data) + int'(pbit)) % 2) != int'(ohel));
    m_ferr = !stop;
    m_ovf  = m_rdy && !clr_done;
    m_rdy  = 1'b1;
  endtask

  // Called at a negedge; drives one line cycle per negedge. Indices < 0 disable the event.
  task automatic send(input logic [11:0] f, input int nb, input int clr_at,
                      input int glitch_at, input int rst_at);
    int kk;
    kk = int'(k) + 1;
    for (int t = 0; t < nb * kk; t++) begin
      rx  = f[t / kk] ^ (t == glitch_at);
      clr = (t == clr_at);
      if (t == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("rst.data", data, 8'h00);
        chk("rst.rxrdy", {7'b0, RXRDY}, 8'h00);
        chk("rst.perr", {7'b0, PERR}, 8'h00);
        chk("rst.ferr", {7'b0, FERR}, 8'h00);
        chk("rst.ovf", {7'b0, OVF}, 8'h00);
        {m_data, m_rdy, m_perr, m_ferr, m_ovf} = '0;
        rx  = 1'b1;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    rx  = 1'b1;
    clr = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_rdy = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic pbit, input logic stop, input string tag);
    logic [11:0] f;
    int nb;
    build(d, pbit, stop, f, nb);
    send(f, nb, -1, -1, -1);
    model_frame(d, pbit, stop, 1'b0);
    repeat (8) @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    logic [11:0] f;
    int nb, h;
    logic [7:0] d;
    logic pb, sb;
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    k = 19'd15; eight = 1'b1; parity_en = 1'b1; ohel = 1'b0;
    frame(8'hA5, 1'b0, 1'b1, "a5_even_ok");
    pulse_clr();
    check_all("a5_clr");
    frame(8'hA5, 1'b1, 1'b1, "a5_perr");
    pulse_clr();
    frame(8'h3C, 1'b0, 1'b1, "3c_even_ok");
    ohel = 1'b1;
    frame(8'h3C, 1'b1, 1'b1, "3c_odd_ok");

    eight = 1'b0; parity_en = 1'b0;
    frame(8'h55, 1'b0, 1'b0, "7bit_ferr");

    eight = 1'b1; parity_en = 1'b0;
    pulse_clr();
    build(8'h11, 1'b0, 1'b1, f, nb);
    send(f, nb, -1, -1, -1);
    model_frame(8'h11, 1'b0, 1'b1, 1'b0);
    build(8'h22, 1'b0, 1'b1, f, nb);
    send(f, nb, -1, -1, -1);
    model_frame(8'h22, 1'b0, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    check_all("b2b_ovf");
    h = int'(k) >> 1;
    build(8'h33, 1'b0, 1'b1, f, nb);
    send(f, nb, 4 + h + (nb - 1) * (int'(k) + 1) + MAJ, -1, -1);
    model_frame(8'h33, 1'b0, 1'b1, 1'b1);
    repeat (8) @(negedge clk);
    check_all("clr_at_done");

    pulse_clr();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_all("false_start");
    frame(8'h6E, 1'b0, 1'b1, "after_false");

    // One-cycle high pulse exactly on data bit 2's nominal sample point.
    build(8'h00, 1'b0, 1'b1, f, nb);
    send(f, nb, -1, 1 + h + 3 * (int'(k) + 1), -1);
    model_frame(MAJ ? 8'h00 : 8'h04, 1'b0, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    check_all("glitch");

    build(8'h81, 1'b0, 1'b1, f, nb);
    send(f, nb, -1, -1, 4 * (int'(k) + 1) + 8);
    repeat (4) @(negedge clk);
    check_all("post_rst");
    frame(8'h81, 1'b0, 1'b1, "81_after_rst");

    for (int i = 0; i < 10; i++) begin
      k = 19'($urandom_range(6, 24));
      eight = 1'($urandom_range(0, 1));
      parity_en = 1'($urandom_range(0, 1));
      ohel = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      sb = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) pulse_clr();
      frame(d, pb, sb, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
